// File: rtl/uniboard_bus_master_if.sv
// Uniboard host-link and register-bus signal bundle.
//   rx_*          : command bytes from the host link (valid/ready)
//   tx_*          : reply bytes to the host link (valid/ready)
//   register_addr, rw, select : access control driven by the master
//   reg_size      : size reported by the selected responder
// databus is not in this bundle: it is a resolved tristate net and is
// carried as a plain inout port so each driver resolves at a module boundary.
interface uniboard_bus_master_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] reg_size;
  logic [7:0] register_addr;
  logic       rw;
  logic       select;

  modport master (
    input  rx_data, rx_valid, tx_ready, reg_size,
    output rx_ready, tx_data, tx_valid, register_addr, rw, select
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, reg_size,
    input  rx_ready, tx_data, tx_valid, register_addr, rw, select
  );
endinterface

// File: rtl/uniboard_bus_master.sv
// uniboard_bus_master
//   Takes command bytes from the host link, performs one register read or
//   write on the Uniboard peripheral bus, and returns read data as reply bytes.
// Ports
//   clk_12MHz : system clock, rising edge
//   resetn    : asynchronous active-low reset (released synchronously inside)
//   bus       : host link rx/tx handshakes and register bus control (master side)
//   databus   : 32-bit bidirectional register data, driven only during writes
// Command: header {rw, 4'bx, len[2:0]}, address, then len LE data bytes (writes).
module uniboard_bus_master #(
  parameter int SEL_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 120000
) (
  input  logic                         clk_12MHz,
  input  logic                         resetn,
  uniboard_bus_master_if.master        bus,
  inout  wire  [31:0]                  databus
);

  localparam int SW = $clog2(SEL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(SEL_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_SETUP, S_STROBE, S_HOLD, S_REPLY
  } state_e;

  // Reset asserts immediately but leaves on a clock edge, so no flop sees
  // a release close to its capture window.
  logic rst_meta_q, rst_n_q;
  always_ff @(posedge clk_12MHz or negedge resetn) begin
    if (!resetn) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  state_e          state_q,    state_d;
  logic            cmd_rw_q,   cmd_rw_d;
  logic [2:0]      len_q,      len_d;
  logic [7:0]      addr_q,     addr_d;
  logic [31:0]     wdata_q,    wdata_d;
  logic [2:0]      bcnt_q,     bcnt_d;
  logic [SW-1:0]   sel_cnt_q,  sel_cnt_d;
  logic [TW-1:0]   tmo_q,      tmo_d;
  logic [31:0]     rdata_q,    rdata_d;
  logic [2:0]      rsize_q,    rsize_d;
  logic [2:0]      sent_q,     sent_d;
  logic            rx_ready_q, rx_ready_d;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q,  tx_data_d;
  logic            select_q,   select_d;
  logic            rw_out_q,   rw_out_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic            drive_q,    drive_d;

  logic       rx_fire, tx_fire, go_setup;
  logic [2:0] ndata;

  assign rx_fire = bus.rx_valid & rx_ready_q;
  assign tx_fire = tx_valid_q & bus.tx_ready;
  // Header byte reports the raw size; payload never exceeds the 32-bit word.
  assign ndata   = (rsize_q > 3'd4) ? 3'd4 : rsize_q;

  always_comb begin
    state_d    = state_q;
    cmd_rw_d   = cmd_rw_q;
    len_d      = len_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bcnt_d     = bcnt_q;
    sel_cnt_d  = sel_cnt_q;
    tmo_d      = tmo_q;
    rdata_d    = rdata_q;
    rsize_d    = rsize_q;
    sent_d     = sent_q;
    rx_ready_d = rx_ready_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    select_d   = select_q;
    rw_out_d   = rw_out_q;
    reg_addr_d = reg_addr_q;
    drive_d    = drive_q;
    go_setup   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_fire) begin
          cmd_rw_d = bus.rx_data[7];
          len_d    = bus.rx_data[2:0];
          tmo_d    = '0;
          state_d  = S_ADDR;
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          tmo_d  = '0;
          addr_d = bus.rx_data;
          if (cmd_rw_q) begin
            go_setup = 1'b1;
          end else if (len_q == 3'd0 || len_q > 3'd4) begin
            state_d = S_IDLE;   // unusable write length: drop quietly
          end else begin
            wdata_d = '0;
            bcnt_d  = '0;
            state_d = S_WDATA;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WDATA: begin
        if (rx_fire) begin
          tmo_d = '0;
          wdata_d[{bcnt_q[1:0], 3'b000} +: 8] = bus.rx_data;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q + 3'd1 == len_q) go_setup = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_SETUP: begin
        select_d  = 1'b1;
        sel_cnt_d = '0;
        state_d   = S_STROBE;
      end

      S_STROBE: begin
        if (sel_cnt_q == SEL_LAST) begin
          rdata_d  = databus;
          rsize_d  = bus.reg_size;
          select_d = 1'b0;
          state_d  = S_HOLD;
        end else begin
          sel_cnt_d = sel_cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        drive_d  = 1'b0;
        rw_out_d = 1'b1;
        if (cmd_rw_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = {5'd0, rsize_q};
          sent_d     = '0;
          state_d    = S_REPLY;
        end else begin
          rx_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_REPLY: begin
        if (tx_fire) begin
          if (sent_q == ndata) begin
            tx_valid_d = 1'b0;
            rx_ready_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            tx_data_d = rdata_q[{sent_q[1:0], 3'b000} +: 8];
            sent_d    = sent_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Shared entry into SETUP: present address/rw/data one cycle before select.
    if (go_setup) begin
      state_d    = S_SETUP;
      rx_ready_d = 1'b0;
      reg_addr_d = (state_q == S_ADDR) ? bus.rx_data : addr_q;
      rw_out_d   = cmd_rw_q;
      drive_d    = ~cmd_rw_q;
    end
  end

  always_ff @(posedge clk_12MHz or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q    <= S_IDLE;
      cmd_rw_q   <= 1'b1;
      len_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bcnt_q     <= '0;
      sel_cnt_q  <= '0;
      tmo_q      <= '0;
      rdata_q    <= '0;
      rsize_q    <= '0;
      sent_q     <= '0;
      rx_ready_q <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      select_q   <= 1'b0;
      rw_out_q   <= 1'b1;
      reg_addr_q <= '0;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_rw_q   <= cmd_rw_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      bcnt_q     <= bcnt_d;
      sel_cnt_q  <= sel_cnt_d;
      tmo_q      <= tmo_d;
      rdata_q    <= rdata_d;
      rsize_q    <= rsize_d;
      sent_q     <= sent_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      select_q   <= select_d;
      rw_out_q   <= rw_out_d;
      reg_addr_q <= reg_addr_d;
      drive_q    <= drive_d;
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.select        = select_q;
  assign bus.rw            = rw_out_q;
  assign bus.register_addr = reg_addr_q;

  // drive_q only rises with rw=0 and falls together with rw returning to 1.
  assign databus = drive_q ? wdata_q : 32'bz;

endmodule

// File: tb/tb_uniboard_bus_master.sv
module tb_uniboard_bus_master;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uniboard_bus_master_if bus_if();
  wire [31:0] databus;

  logic        resp_en = 1'b0;
  logic [31:0] resp_val = '0;
  logic        resp_force = 1'b0;
  logic [31:0] force_val = 32'hA5A5A5A5;
  logic        resp_drv;

  // Responder drives only during read strobes; resp_force probes for a released bus.
  assign resp_drv = bus_if.select && bus_if.rw && resp_en;
  assign databus = resp_drv ? resp_val : 32'bz;
  assign databus = resp_force ? force_val : 32'bz;

  uniboard_bus_master #(.SEL_CYCLES(4), .TIMEOUT_CYCLES(200)) dut (
    .clk_12MHz (clk),
    .resetn    (resetn),
    .bus       (bus_if.master),
    .databus   (databus)
  );

  int checks = 0;
  int errors = 0;
  int sel_hi = 0;
  int sel_rise = 0;
  logic sel_prev = 1'b0;
  logic [7:0] tx_q[$];

  always @(negedge clk) begin
    if (bus_if.select) sel_hi++;
    if (bus_if.select && !sel_prev) sel_rise++;
    sel_prev = bus_if.select;
    if (bus_if.tx_valid && bus_if.tx_ready && resetn) tx_q.push_back(bus_if.tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    while (!bus_if.rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("rx_ready_wait", {31'd0, bus_if.rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int c = 0;
    while (tx_q.size() < n && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("tx_count", tx_q.size(), n);
  endtask

  task automatic check_released(input string tag);
    resp_force = 1'b1;
    #1;
    chk(tag, databus, 32'hA5A5A5A5);
    resp_force = 1'b0;
  endtask

  initial begin
    int sh0, sr0, tb0, bad;
    bus_if.rx_data  = '0;
    bus_if.rx_valid = 1'b0;
    bus_if.tx_ready = 1'b1;
    bus_if.reg_size = '0;

    // Reset state
    #12;
    chk("rst_select", {31'd0, bus_if.select}, 32'd0);
    chk("rst_rw", {31'd0, bus_if.rw}, 32'd1);
    chk("rst_addr", {24'd0, bus_if.register_addr}, 32'd0);
    chk("rst_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);
    chk("rst_tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus_if.tx_data}, 32'd0);
    check_released("rst_databus_z");
    @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // Full 4-byte write
    sh0 = sel_hi; sr0 = sel_rise; tb0 = tx_q.size();
    send_byte(8'h04); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    @(negedge clk);
    chk("wr_setup_select", {31'd0, bus_if.select}, 32'd0);
    chk("wr_addr", {24'd0, bus_if.register_addr}, 32'h12);
    chk("wr_rw", {31'd0, bus_if.rw}, 32'd0);
    chk("wr_databus", databus, 32'h12345678);
    chk("wr_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
    @(negedge clk);
    chk("wr_latency_select", {31'd0, bus_if.select}, 32'd1);
    repeat (8) @(negedge clk);
    chk("wr_sel_cycles", sel_hi - sh0, 32'd4);
    chk("wr_sel_pulses", sel_rise - sr0, 32'd1);
    chk("wr_rw_after", {31'd0, bus_if.rw}, 32'd1);
    chk("wr_no_tx", tx_q.size() - tb0, 32'd0);
    check_released("wr_databus_released");

    // Read of a 4-byte register
    bus_if.reg_size = 3'd4; resp_val = 32'hDEADBEEF; resp_en = 1'b1;
    tb0 = tx_q.size();
    send_byte(8'h80); send_byte(8'h03);
    wait_tx(tb0 + 5);
    if (tx_q.size() >= tb0 + 5) begin
      chk("rd_b0", {24'd0, tx_q[tb0]},   32'h04);
      chk("rd_b1", {24'd0, tx_q[tb0+1]}, 32'hEF);
      chk("rd_b2", {24'd0, tx_q[tb0+2]}, 32'hBE);
      chk("rd_b3", {24'd0, tx_q[tb0+3]}, 32'hAD);
      chk("rd_b4", {24'd0, tx_q[tb0+4]}, 32'hDE);
    end
    repeat (5) @(negedge clk);
    chk("rd_addr", {24'd0, bus_if.register_addr}, 32'h03);
    chk("rd_only5", tx_q.size() - tb0, 32'd5);
    chk("rd_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);

    // Unmapped read: single 0x00
    bus_if.reg_size = 3'd0;
    tb0 = tx_q.size();
    send_byte(8'h80); send_byte(8'h7F);
    wait_tx(tb0 + 1);
    repeat (10) @(negedge clk);
    chk("unmapped_count", tx_q.size() - tb0, 32'd1);
    if (tx_q.size() > tb0) chk("unmapped_byte", {24'd0, tx_q[tb0]}, 32'h00);

    // Oversize reg_size: header raw 6, payload clamped to 4 bytes
    bus_if.reg_size = 3'd6; resp_val = 32'h44332211;
    tb0 = tx_q.size();
    send_byte(8'h80); send_byte(8'h05);
    wait_tx(tb0 + 5);
    repeat (10) @(negedge clk);
    chk("clamp_count", tx_q.size() - tb0, 32'd5);
    if (tx_q.size() >= tb0 + 5) begin
      chk("clamp_hdr", {24'd0, tx_q[tb0]}, 32'h06);
      chk("clamp_last", {24'd0, tx_q[tb0+4]}, 32'h44);
    end

    // Short write, len 2
    send_byte(8'h02); send_byte(8'h40); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clk);
    chk("short_wr_data", databus, 32'h0000BBAA);
    chk("short_wr_addr", {24'd0, bus_if.register_addr}, 32'h40);
    repeat (8) @(negedge clk);

    // Dropped writes: len 0 and len 5
    sr0 = sel_rise;
    send_byte(8'h00); send_byte(8'h50);
    send_byte(8'h05); send_byte(8'h51);
    repeat (10) @(negedge clk);
    chk("drop_no_select", sel_rise - sr0, 32'd0);
    chk("drop_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);

    // Timeout of a partial write, then a normal read
    sr0 = sel_rise;
    send_byte(8'h04); send_byte(8'h20);
    repeat (250) @(negedge clk);
    chk("tmo_no_select", sel_rise - sr0, 32'd0);
    bus_if.reg_size = 3'd2; resp_val = 32'hCAFE1234;
    tb0 = tx_q.size();
    send_byte(8'h80); send_byte(8'h20);
    wait_tx(tb0 + 3);
    if (tx_q.size() >= tb0 + 3) begin
      chk("tmo_rd_b0", {24'd0, tx_q[tb0]},   32'h02);
      chk("tmo_rd_b1", {24'd0, tx_q[tb0+1]}, 32'h34);
      chk("tmo_rd_b2", {24'd0, tx_q[tb0+2]}, 32'h12);
    end
    repeat (5) @(negedge clk);

    // Backpressure mid-reply
    bus_if.reg_size = 3'd4; resp_val = 32'hDEADBEEF;
    @(posedge clk); #1; bus_if.tx_ready = 1'b0;
    tb0 = tx_q.size();
    send_byte(8'h80); send_byte(8'h03);
    bad = 0;
    while (!bus_if.tx_valid && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    chk("bp_tx_valid", {31'd0, bus_if.tx_valid}, 32'd1);
    @(posedge clk); #1; bus_if.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; bus_if.tx_ready = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus_if.tx_data !== 8'hBE || !bus_if.tx_valid || bus_if.rx_ready) bad++;
    end
    chk("bp_stable", bad, 32'd0);
    chk("bp_tx_data", {24'd0, bus_if.tx_data}, 32'hBE);
    chk("bp_rx_ready", {31'd0, bus_if.rx_ready}, 32'd0);
    @(posedge clk); #1; bus_if.tx_ready = 1'b1;
    wait_tx(tb0 + 5);
    if (tx_q.size() >= tb0 + 5) begin
      chk("bp_b1", {24'd0, tx_q[tb0+1]}, 32'hEF);
      chk("bp_b2", {24'd0, tx_q[tb0+2]}, 32'hBE);
      chk("bp_b4", {24'd0, tx_q[tb0+4]}, 32'hDE);
    end
    repeat (5) @(negedge clk);

    // Reset during STROBE of a write
    tb0 = tx_q.size();
    send_byte(8'h04); send_byte(8'h60);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_select_hi", {31'd0, bus_if.select}, 32'd1);
    chk("rstmid_driving", databus, 32'h44332211);
    #2; resetn = 1'b0;
    #1;
    chk("rstmid_select_lo", {31'd0, bus_if.select}, 32'd0);
    chk("rstmid_rw", {31'd0, bus_if.rw}, 32'd1);
    check_released("rstmid_databus_z");
    @(negedge clk); resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_no_tx", tx_q.size() - tb0, 32'd0);
    chk("rstmid_rx_ready", {31'd0, bus_if.rx_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
